// File: rtl/sopc_pkg.sv
// Shared types for the SoPC memory controller: FSM states, arbitration modes,
// port identifiers and the system address width.
package sopc_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    typedef enum logic {
        PORT_DATA = 1'b0,
        PORT_INST = 1'b1
    } port_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter: fixed data-port priority or round-robin on contention.
// grant bit 0 is the data port, bit 1 the instruction port.
module rr_arb2
    import sopc_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic [1:0] req,
    input  arb_mode_t mode,
    input  logic      take,
    output logic [1:0] grant
);

    // Port that wins the next contention; starts at the data port.
    port_t prio_reg;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (mode == ARB_RR && prio_reg == PORT_INST) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_reg <= PORT_DATA;
        end else if (take && grant != 2'b00) begin
            prio_reg <= grant[0] ? PORT_INST : PORT_DATA;
        end
    end

endmodule

// File: rtl/sopc_mem_ctrl.sv
// Single-port on-chip memory shared by an instruction fetch port and a data port,
// with a programmable number of wait states and byte-lane writes.
module sopc_mem_ctrl
    import sopc_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4096,
    parameter int WAIT_ST  = 1,
    parameter int ARB_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_ce,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic [DATA_W-1:0]     inst_rdata,
    output logic                  inst_ack,
    output logic                  inst_stall,
    input  logic                  mem_ce,
    input  logic                  mem_we,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W/8-1:0]   mem_sel,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_ack,
    output logic                  mem_stall,
    output logic                  mem_err
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_B = (LANES > 1) ? $clog2(LANES) : 0;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam arb_mode_t ARB_SEL = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;

    logic [DATA_W-1:0] ram [DEPTH];

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    port_t             port_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] word_idx_reg;
    logic [LANES-1:0]  sel_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] inst_rdata_reg, mem_rdata_reg;
    logic              inst_ack_reg, mem_ack_reg, mem_err_reg;

    logic [1:0]        grant;
    logic              start;
    logic              in_range;
    logic [IDX_W-1:0]  ram_idx;
    logic [DATA_W-1:0] rd_word;

    assign start    = (state_reg == ST_IDLE) && (inst_ce || mem_ce);
    assign in_range = word_idx_reg < ADDR_W'(DEPTH);
    assign ram_idx  = word_idx_reg[IDX_W-1:0];
    assign rd_word  = in_range ? ram[ram_idx] : '0;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({inst_ce, mem_ce}),
        .mode  (ARB_SEL),
        .take  (start),
        .grant (grant)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    cnt_next   = 4'(WAIT_ST);
                    state_next = (WAIT_ST == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg <= 4'd1) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 4'd0;
            port_reg       <= PORT_DATA;
            we_reg         <= 1'b0;
            word_idx_reg   <= '0;
            sel_reg        <= '0;
            wdata_reg      <= '0;
            inst_rdata_reg <= '0;
            mem_rdata_reg  <= '0;
            inst_ack_reg   <= 1'b0;
            mem_ack_reg    <= 1'b0;
            mem_err_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            inst_ack_reg <= 1'b0;
            mem_ack_reg  <= 1'b0;
            mem_err_reg  <= 1'b0;
            // Everything the access needs is captured here; requester inputs are ignored afterwards.
            if (start) begin
                port_reg     <= grant[1] ? PORT_INST : PORT_DATA;
                we_reg       <= grant[0] & mem_we;
                word_idx_reg <= (grant[1] ? inst_addr : mem_addr) >> LANE_B;
                sel_reg      <= mem_sel;
                wdata_reg    <= mem_wdata;
            end
            if (state_reg == ST_RESP) begin
                mem_err_reg <= !in_range;
                if (port_reg == PORT_INST) begin
                    inst_ack_reg   <= 1'b1;
                    inst_rdata_reg <= rd_word;
                end else begin
                    mem_ack_reg <= 1'b1;
                    if (!we_reg) begin
                        mem_rdata_reg <= rd_word;
                    end
                end
            end
        end
    end

    // No reset on the array so contents survive rst; an abort clears state_reg first.
    always_ff @(posedge clk) begin
        if (state_reg == ST_RESP && we_reg && in_range) begin
            for (int b = 0; b < LANES; b++) begin
                if (sel_reg[b]) begin
                    ram[ram_idx][b*8 +: 8] <= wdata_reg[b*8 +: 8];
                end
            end
        end
    end

    assign inst_rdata = inst_rdata_reg;
    assign inst_ack   = inst_ack_reg;
    assign mem_rdata  = mem_rdata_reg;
    assign mem_ack    = mem_ack_reg;
    assign mem_err    = mem_err_reg;
    assign inst_stall = inst_ce & ~inst_ack_reg;
    assign mem_stall  = mem_ce & ~mem_ack_reg;

endmodule

// File: tb/tb_sopc_mem_ctrl.sv
// Randomized self-checking bench for sopc_mem_ctrl: a round-robin instance with one
// wait state and a fixed-priority instance with zero wait states, both 16 words deep.
module tb_sopc_mem_ctrl;

    localparam int WS_A = 1;
    localparam int WS_B = 0;
    localparam int DEP  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_inst_ce = 1'b0, a_mem_ce = 1'b0, a_mem_we = 1'b0;
    logic [31:0] a_inst_addr = '0, a_mem_addr = '0, a_mem_wdata = '0;
    logic [3:0]  a_mem_sel = '0;
    logic [31:0] a_inst_rdata, a_mem_rdata;
    logic        a_inst_ack, a_inst_stall, a_mem_ack, a_mem_stall, a_mem_err;

    logic        b_inst_ce = 1'b0, b_mem_ce = 1'b0, b_mem_we = 1'b0;
    logic [31:0] b_inst_addr = '0, b_mem_addr = '0, b_mem_wdata = '0;
    logic [3:0]  b_mem_sel = '0;
    logic [31:0] b_inst_rdata, b_mem_rdata;
    logic        b_inst_ack, b_inst_stall, b_mem_ack, b_mem_stall, b_mem_err;

    sopc_mem_ctrl #(.DATA_W(32), .DEPTH(DEP), .WAIT_ST(WS_A), .ARB_MODE(1)) dut_a (
        .clk(clk), .rst(rst),
        .inst_ce(a_inst_ce), .inst_addr(a_inst_addr), .inst_rdata(a_inst_rdata),
        .inst_ack(a_inst_ack), .inst_stall(a_inst_stall),
        .mem_ce(a_mem_ce), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_sel(a_mem_sel),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .mem_ack(a_mem_ack),
        .mem_stall(a_mem_stall), .mem_err(a_mem_err)
    );

    sopc_mem_ctrl #(.DATA_W(32), .DEPTH(DEP), .WAIT_ST(WS_B), .ARB_MODE(0)) dut_b (
        .clk(clk), .rst(rst),
        .inst_ce(b_inst_ce), .inst_addr(b_inst_addr), .inst_rdata(b_inst_rdata),
        .inst_ack(b_inst_ack), .inst_stall(b_inst_stall),
        .mem_ce(b_mem_ce), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_sel(b_mem_sel),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_ack(b_mem_ack),
        .mem_stall(b_mem_stall), .mem_err(b_mem_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference memory contents, one word per entry.
    logic [31:0] ref_a [DEP];
    logic [31:0] ref_b [DEP];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (sel[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access on dut_a. lat = edges from the drive point to ack (sampling edge is 1),
    // -1 on timeout. Always called #1 after an edge with the controller idle.
    task automatic acc_a(input bit inst, input bit we, input logic [31:0] addr, input logic [3:0] sel,
                         input logic [31:0] wdata, input bit drop, output logic [31:0] rd,
                         output logic err, output int lat, output bit stall_ok, output bit pulse_ok);
        logic ack;
        if (inst) begin
            a_inst_ce = 1'b1; a_inst_addr = addr;
        end else begin
            a_mem_ce = 1'b1; a_mem_we = we; a_mem_addr = addr; a_mem_sel = sel; a_mem_wdata = wdata;
        end
        #1;
        stall_ok = ((inst ? a_inst_stall : a_mem_stall) === 1'b1);
        lat = 0;
        ack = 1'b0;
        while (ack !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (drop && lat == 1) begin
                a_inst_ce = 1'b0; a_mem_ce = 1'b0;
                a_inst_addr = $urandom; a_mem_addr = $urandom; a_mem_we = 1'($urandom);
                a_mem_sel = 4'($urandom); a_mem_wdata = $urandom;
            end
            ack = inst ? a_inst_ack : a_mem_ack;
            if (!drop) stall_ok &= ((inst ? a_inst_stall : a_mem_stall) === ~ack);
        end
        if (ack !== 1'b1) lat = -1;
        rd  = inst ? a_inst_rdata : a_mem_rdata;
        err = a_mem_err;
        a_inst_ce = 1'b0;
        a_mem_ce  = 1'b0;
        tick();
        pulse_ok = (a_inst_ack === 1'b0) && (a_mem_ack === 1'b0) && (a_mem_err === 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_mem_ce = 1'b1;
        repeat (3) tick();
        total++;
        if ({a_inst_ack, a_mem_ack, a_mem_err, b_inst_ack, b_mem_ack, b_mem_err} !== 6'b0) begin
            bad++; $display("FAIL reset_acks got=%b want=000000", {a_inst_ack, a_mem_ack, a_mem_err, b_inst_ack, b_mem_ack, b_mem_err});
        end
        total++;
        if ({a_inst_rdata, a_mem_rdata, b_inst_rdata, b_mem_rdata} !== 128'b0) begin
            bad++; $display("FAIL reset_rdata got=%h %h %h %h want=0", a_inst_rdata, a_mem_rdata, b_inst_rdata, b_mem_rdata);
        end
        total++;
        if ({a_mem_stall, a_inst_stall} !== 2'b10) begin
            bad++; $display("FAIL reset_stall got=%b want=10", {a_mem_stall, a_inst_stall});
        end
        a_mem_ce = 1'b0;
        rst = 1'b1;
        tick();
        $display("reset: outputs checked");
    endtask

    task automatic test_fill();
        logic [31:0] rd, d;
        logic err;
        int lat, cyc;
        bit s_ok, p_ok;
        for (int i = 0; i < DEP; i++) begin
            d = $urandom;
            acc_a(1'b0, 1'b1, 32'(i * 4), 4'hF, d, 1'b0, rd, err, lat, s_ok, p_ok);
            ref_a[i] = d;
            total++;
            if (lat != WS_A + 2 || err !== 1'b0) begin
                bad++; $display("FAIL fill_a word=%0d lat=%0d err=%b want lat=%0d err=0", i, lat, err, WS_A + 2);
            end
        end
        for (int i = 0; i < DEP; i++) begin
            d = $urandom;
            b_mem_ce = 1'b1; b_mem_we = 1'b1; b_mem_addr = 32'(i * 4); b_mem_sel = 4'hF; b_mem_wdata = d;
            cyc = 0;
            do begin tick(); cyc++; end while (b_mem_ack !== 1'b1 && cyc < 20);
            b_mem_ce = 1'b0;
            ref_b[i] = d;
            total++;
            if (cyc != WS_B + 2) begin
                bad++; $display("FAIL fill_b word=%0d lat=%0d want=%0d", i, cyc, WS_B + 2);
            end
            tick();
        end
        $display("fill: both memories initialised");
    endtask

    task automatic test_single_read();
        logic [31:0] rd;
        logic err;
        int lat;
        bit s_ok, p_ok;
        acc_a(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, rd, err, lat, s_ok, p_ok);
        ref_a[4] = 32'hDEADBEEF;
        acc_a(1'b0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, rd, err, lat, s_ok, p_ok);
        total++;
        if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL single_read_data got=%h want=deadbeef", rd); end
        total++;
        // WAIT_ST=1: ack is high in the third cycle after the sampling edge.
        if (lat != 3) begin bad++; $display("FAIL single_read_latency got=%0d want=3", lat); end
        total++;
        if (!s_ok || !p_ok || err !== 1'b0) begin
            bad++; $display("FAIL single_read_handshake stall_ok=%0b pulse_ok=%0b err=%b want 1 1 0", s_ok, p_ok, err);
        end
        acc_a(1'b0, 1'b1, 32'h14, 4'hF, 32'h5A5A5A5A, 1'b0, rd, err, lat, s_ok, p_ok);
        ref_a[5] = 32'h5A5A5A5A;
        total++;
        if (a_mem_rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rdata_hold got=%h want=deadbeef", a_mem_rdata);
        end
        $display("single_read: addr=0x10 data=%h lat=%0d", rd, lat);
    endtask

    task automatic test_byte_write();
        logic [31:0] rd;
        logic err;
        int lat;
        bit s_ok, p_ok;
        acc_a(1'b0, 1'b1, 32'h18, 4'hF, 32'h0, 1'b0, rd, err, lat, s_ok, p_ok);
        acc_a(1'b0, 1'b1, 32'h18, 4'b0101, 32'h11223344, 1'b0, rd, err, lat, s_ok, p_ok);
        acc_a(1'b0, 1'b0, 32'h18, 4'h0, 32'h0, 1'b0, rd, err, lat, s_ok, p_ok);
        total++;
        if (rd !== 32'h00220044) begin bad++; $display("FAIL byte_write got=%h want=00220044", rd); end
        acc_a(1'b0, 1'b1, 32'h18, 4'b0000, 32'hFFFFFFFF, 1'b0, rd, err, lat, s_ok, p_ok);
        total++;
        if (lat != WS_A + 2) begin bad++; $display("FAIL sel0_ack lat=%0d want=%0d", lat, WS_A + 2); end
        acc_a(1'b0, 1'b0, 32'h1A, 4'h0, 32'h0, 1'b0, rd, err, lat, s_ok, p_ok);
        total++;
        if (rd !== 32'h00220044) begin bad++; $display("FAIL sel0_unchanged got=%h want=00220044", rd); end
        ref_a[6] = 32'h00220044;
        $display("byte_write: word6=%h", rd);
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wd, exp_rd;
        logic [3:0] sel;
        logic err;
        bit inst, we, drop, s_ok, p_ok;
        int lat, idx;
        for (int n = 0; n < 40; n++) begin
            inst = 1'($urandom);
            we   = inst ? 1'b0 : 1'($urandom);
            drop = ($urandom_range(0, 7) == 0);
            addr = 32'($urandom_range(0, 95));
            sel  = 4'($urandom);
            wd   = $urandom;
            idx  = int'(addr / 4);
            acc_a(inst, we, addr, sel, wd, drop, rd, err, lat, s_ok, p_ok);
            exp_rd = (idx < DEP) ? ref_a[idx] : 32'h0;
            if (we && idx < DEP) ref_a[idx] = merge(ref_a[idx], wd, sel);
            total++;
            if (lat != WS_A + 2 || !p_ok || (!drop && !s_ok)) begin
                bad++; $display("FAIL rand_handshake n=%0d lat=%0d pulse_ok=%0b stall_ok=%0b", n, lat, p_ok, s_ok);
            end
            total++;
            if (err !== (idx >= DEP)) begin
                bad++; $display("FAIL rand_err n=%0d addr=%h got=%b want=%b", n, addr, err, idx >= DEP);
            end
            if (!we) begin
                total++;
                if (rd !== exp_rd) begin
                    bad++; $display("FAIL rand_rdata n=%0d addr=%h got=%h want=%h", n, addr, rd, exp_rd);
                end
            end
            $display("random n=%0d port=%s we=%0b addr=%h sel=%h drop=%0b rd=%h err=%b", n, inst ? "inst" : "data", we, addr, sel, drop, rd, err);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        logic err;
        int lat;
        bit s_ok, p_ok;
        acc_a(1'b0, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, rd, err, lat, s_ok, p_ok);
        total++;
        if (rd !== 32'h0 || err !== 1'b1) begin bad++; $display("FAIL oor_read rd=%h err=%b want 0 1", rd, err); end
        acc_a(1'b0, 1'b1, 32'h40, 4'hF, 32'hFFFFFFFF, 1'b0, rd, err, lat, s_ok, p_ok);
        total++;
        if (err !== 1'b1 || lat != WS_A + 2) begin bad++; $display("FAIL oor_write err=%b lat=%0d want 1 %0d", err, lat, WS_A + 2); end
        for (int i = 0; i < DEP; i++) begin
            acc_a(1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0, 1'b0, rd, err, lat, s_ok, p_ok);
            total++;
            if (rd !== ref_a[i] || err !== 1'b0) begin
                bad++; $display("FAIL oor_intact word=%0d got=%h err=%b want=%h", i, rd, err, ref_a[i]);
            end
        end
        acc_a(1'b1, 1'b0, 32'h7C, 4'h0, 32'h0, 1'b0, rd, err, lat, s_ok, p_ok);
        total++;
        if (rd !== 32'h0 || err !== 1'b1) begin bad++; $display("FAIL oor_fetch rd=%h err=%b want 0 1", rd, err); end
        $display("out_of_range: done");
    endtask

    task automatic test_contention();
        int n, cyc, last, stall_bad;
        bit exp_inst, got_inst;
        logic [31:0] got_rd, exp_rd;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        a_mem_ce = 1'b1; a_mem_we = 1'b0; a_mem_addr = 32'h4;
        a_inst_ce = 1'b1; a_inst_addr = 32'h8;
        n = 0; cyc = 0; last = 0; stall_bad = 0;
        exp_inst = 1'b0;  // first grant after reset goes to the data port
        while (n < 4 && cyc < 60) begin
            tick();
            cyc++;
            if (a_mem_stall !== ~a_mem_ack || a_inst_stall !== ~a_inst_ack) stall_bad++;
            if (a_mem_ack === 1'b1 || a_inst_ack === 1'b1) begin
                got_inst = (a_inst_ack === 1'b1);
                got_rd   = got_inst ? a_inst_rdata : a_mem_rdata;
                exp_rd   = got_inst ? ref_a[2] : ref_a[1];
                total++;
                if (got_inst != exp_inst || (a_mem_ack & a_inst_ack) === 1'b1) begin
                    bad++; $display("FAIL rr_order n=%0d got=%s want=%s", n, got_inst ? "inst" : "data", exp_inst ? "inst" : "data");
                end
                total++;
                if (got_rd !== exp_rd) begin bad++; $display("FAIL rr_rdata n=%0d got=%h want=%h", n, got_rd, exp_rd); end
                total++;
                if (cyc - last != WS_A + 2) begin bad++; $display("FAIL rr_period n=%0d got=%0d want=%0d", n, cyc - last, WS_A + 2); end
                $display("contention n=%0d grant=%s rd=%h", n, got_inst ? "inst" : "data", got_rd);
                last = cyc;
                exp_inst = !exp_inst;
                n++;
            end
        end
        total++;
        if (n != 4) begin bad++; $display("FAIL rr_timeout acks=%0d want=4", n); end
        total++;
        if (stall_bad != 0) begin bad++; $display("FAIL rr_stall bad_cycles=%0d want=0", stall_bad); end
        a_mem_ce = 1'b0; a_inst_ce = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, old;
        logic err;
        int lat, acks;
        bit s_ok, p_ok;
        for (int k = 1; k <= 2; k++) begin
            old = ref_a[7];
            a_mem_ce = 1'b1; a_mem_we = 1'b1; a_mem_addr = 32'h1C; a_mem_sel = 4'hF; a_mem_wdata = 32'hCAFEF00D;
            repeat (k) tick();
            rst = 1'b0;
            a_mem_ce = 1'b0;
            acks = 0;
            repeat (3) begin tick(); if (a_mem_ack === 1'b1 || a_inst_ack === 1'b1) acks++; end
            rst = 1'b1;
            tick();
            if (a_mem_ack === 1'b1 || a_inst_ack === 1'b1) acks++;
            total++;
            if (acks != 0) begin bad++; $display("FAIL abort_ack k=%0d acks=%0d want=0", k, acks); end
            acc_a(1'b0, 1'b0, 32'h1C, 4'h0, 32'h0, 1'b0, rd, err, lat, s_ok, p_ok);
            total++;
            if (rd !== old) begin bad++; $display("FAIL abort_word k=%0d got=%h want=%h", k, rd, old); end
            total++;
            if (lat != WS_A + 2) begin bad++; $display("FAIL abort_idle k=%0d lat=%0d want=%0d", k, lat, WS_A + 2); end
            $display("reset_mid k=%0d word7=%h", k, rd);
        end
    endtask

    task automatic test_back_to_back();
        int n, cyc, last, idx;
        logic [31:0] cur;
        cur = 32'($urandom_range(0, DEP - 1) * 4);
        b_inst_ce = 1'b1; b_inst_addr = cur;
        n = 0; cyc = 0; last = 0;
        while (n < 8 && cyc < 100) begin
            tick();
            cyc++;
            if (b_inst_ack === 1'b1) begin
                idx = int'(cur / 4);
                total++;
                if (b_inst_rdata !== ref_b[idx]) begin
                    bad++; $display("FAIL b2b_rdata n=%0d addr=%h got=%h want=%h", n, cur, b_inst_rdata, ref_b[idx]);
                end
                total++;
                if (cyc - last != 2) begin bad++; $display("FAIL b2b_period n=%0d got=%0d want=2", n, cyc - last); end
                $display("back_to_back n=%0d addr=%h rd=%h", n, cur, b_inst_rdata);
                last = cyc;
                n++;
                cur = 32'($urandom_range(0, DEP - 1) * 4);
                b_inst_addr = cur;
            end
        end
        total++;
        if (n != 8) begin bad++; $display("FAIL b2b_timeout acks=%0d want=8", n); end
        b_inst_ce = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_fixed_prio();
        int n, cyc;
        bit got_inst, exp_inst;
        b_mem_ce = 1'b1; b_mem_we = 1'b0; b_mem_addr = 32'h0;
        b_inst_ce = 1'b1; b_inst_addr = 32'h4;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 60) begin
            tick();
            cyc++;
            if (b_mem_ack === 1'b1 || b_inst_ack === 1'b1) begin
                got_inst = (b_inst_ack === 1'b1);
                exp_inst = (n == 3);  // data wins while it keeps requesting
                total++;
                if (got_inst != exp_inst || (got_inst ? b_inst_rdata : b_mem_rdata) !== (got_inst ? ref_b[1] : ref_b[0])) begin
                    bad++; $display("FAIL fixed_prio n=%0d got=%s rd=%h want=%s", n, got_inst ? "inst" : "data",
                                    got_inst ? b_inst_rdata : b_mem_rdata, exp_inst ? "inst" : "data");
                end
                $display("fixed_prio n=%0d grant=%s", n, got_inst ? "inst" : "data");
                n++;
                if (n == 3) b_mem_ce = 1'b0;
            end
        end
        total++;
        if (n != 4) begin bad++; $display("FAIL fixed_prio_timeout acks=%0d want=4", n); end
        b_mem_ce = 1'b0; b_inst_ce = 1'b0;
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_single_read();
        test_byte_write();
        test_random();
        test_out_of_range();
        test_contention();
        test_reset_mid();
        test_back_to_back();
        test_fixed_prio();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sopc_mem_ctrl.md
SOPC_MEM_CTRL -- requirements
Module: sopc_mem_ctrl

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, data width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 4096, number of DATA_W words of storage.
REQ-003 SHALL have parameter WAIT_ST, default 1, extra access cycles, range 0..15.
REQ-004 SHALL have parameter ARB_MODE, default 0: 0 = fixed data-port priority, 1 = round-robin.
REQ-005 SHALL have ports:
 - clk  in  1  single clock; all state updates on rising edge.
 - rst  in  1  asynchronous, active-low reset.
 - inst_ce  in  1  instruction fetch request.
 - inst_addr  in  32  byte address of the fetch.
 - inst_rdata  out  DATA_W  fetched word.
 - inst_ack  out  1  fetch complete; one-cycle pulse.
 - inst_stall  out  1  fetch pending.
 - mem_ce  in  1  data request.
 - mem_we  in  1  1 = write, 0 = read.
 - mem_addr  in  32  byte address of the data access.
 - mem_sel  in  DATA_W/8  byte-lane write enables.
 - mem_wdata  in  DATA_W  write data.
 - mem_rdata  out  DATA_W  read data.
 - mem_ack  out  1  data access complete; one-cycle pulse.
 - mem_stall  out  1  data access pending.
 - mem_err  out  1  out-of-range access; pulses with mem_ack or inst_ack.

Function
REQ-006 SHALL store data in one single-port array of DEPTH words.
REQ-007 SHALL index the array by address bits above log2(DATA_W/8); the low address bits SHALL be ignored.
REQ-008 SHALL implement the FSM IDLE -> WAIT -> RESP -> IDLE.
 - If WAIT_ST = 0, the FSM SHALL go IDLE -> RESP directly.
REQ-009 In IDLE with at least one ce high, SHALL grant one port and latch that port's addr, we, sel and wdata.
 - SHALL load the wait counter with WAIT_ST.
REQ-010 In WAIT, SHALL decrement the counter each cycle and go to RESP when it reaches 0.
REQ-011 In RESP, SHALL:
 - perform the read or the write;
 - register the read data onto the granted port's rdata;
 - pulse that port's ack for exactly one cycle.
REQ-012 SHALL assert ack exactly WAIT_ST+2 cycles after the rising edge that sampled ce in IDLE.
REQ-013 SHALL hold rdata stable until that port's next ack.
REQ-014 Arbitration when both ce are high in IDLE:
 - ARB_MODE 0: SHALL grant the data port.
 - ARB_MODE 1: SHALL grant the port not granted last; the first grant after reset SHALL go to the data port.
REQ-015 SHALL treat the instruction port as read-only.
REQ-016 On a write, SHALL update only the byte lanes whose sel bit is 1; sel = 0 SHALL leave memory unchanged and still produce an ack.
REQ-017 SHALL drive stall as (ce AND NOT ack), combinationally, per port.
REQ-018 For a word index >= DEPTH:
 - a read SHALL return 0;
 - a write SHALL be discarded;
 - mem_err SHALL pulse with the ack.
REQ-019 If a requester drops ce after grant, SHALL complete the access and still pulse ack.
REQ-020 A requester SHALL hold ce, addr, we, sel and wdata until ack; the block SHALL use only the values latched at grant.
REQ-021 The sustained throughput SHALL be one access per WAIT_ST+2 cycles.

Reset
REQ-022 On rst low, SHALL asynchronously force:
 - FSM = IDLE, wait counter = 0, round-robin pointer = data;
 - inst_ack, mem_ack, mem_err = 0;
 - inst_rdata, mem_rdata = 0.
REQ-023 Reset SHALL NOT clear memory contents.
REQ-024 Reset during WAIT or RESP SHALL abort the access: no write commit and no ack.

Structure
REQ-025 SHALL take the FSM state encoding, ARB_MODE codes and the 32-bit address width from the shared package sopc_pkg.
REQ-026 SHALL place arbitration in one sub-module, rr_arb2: two requests, mode input, registered last-grant pointer, one-hot grant output.

Verification
REQ-027 Single read: WAIT_ST=1, mem_ce=1, mem_we=0, addr 0x10 holding 0xDEADBEEF -> mem_ack high 3 cycles after the sampling edge, mem_rdata = 0xDEADBEEF.
REQ-028 Byte write: write 0x11223344 with sel=4'b0101 to a word holding 0 -> read back 0x00220044.
REQ-029 Contention with ARB_MODE 1: both ce held high for 4 accesses -> grants go data, inst, data, inst; stall is high on each port until its ack.
REQ-030 Out of range: DEPTH=16, read at byte address 0x40 -> mem_rdata = 0, mem_err pulses with mem_ack; a write to 0x40 leaves words 0..15 unchanged.
REQ-031 Reset mid-access: rst low during WAIT of a write of 0xCAFEF00D -> no ack, FSM returns to IDLE, the target word keeps its old value.
REQ-032 WAIT_ST=0: back-to-back fetches -> one inst_ack every 2 cycles.
